// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared helpers and types for the pipelined ripple-carry adder
//
// Purpose : chunk-width helper, configuration legality check and the per-stage
//           control record used by pipelined_rc_adder.
// Ports   : none (package).
package adder_pkg;

    // Width of one ripple chunk; each pipeline stage consumes exactly one.
    function automatic int chunk_w(input int n, input int stages);
        return n / stages;
    endfunction

    // Legal configurations split N evenly into 1..N chunks.
    function automatic bit cfg_ok(input int n, input int stages);
        return (n >= 1) && (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

    // Per-stage control record: occupancy plus the carry leaving the chunk.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
//
// Purpose : one bit of the ripple chain.
// Ports   : a, b, cin -> sum, cout (all 1 bit).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rc_chunk.sv
// rtl/rc_chunk.sv - combinational W-bit ripple-carry chain of full_adder cells
//
// Purpose : adds one chunk of the operands inside a single pipeline stage.
// Ports   : a[W-1:0], b[W-1:0], cin -> sum[W-1:0], cout (carry out of bit W-1),
//           c_msb (carry into bit W-1, used for signed overflow).
module rc_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    // Each bit keeps its own carry wires so the chain is a set of distinct
    // nets rather than one self-referencing vector.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic w_ci;
        logic w_co;
        if (i == 0) begin : g_first
            assign w_ci = cin;
        end else begin : g_chain
            assign w_ci = g_bit[i-1].w_co;
        end
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_ci),
            .sum  (sum[i]),
            .cout (w_co)
        );
    end

    assign cout  = g_bit[W-1].w_co;
    assign c_msb = g_bit[W-1].w_ci;

endmodule

// File: rtl/pipelined_rc_adder.sv
// rtl/pipelined_rc_adder.sv - STAGES-deep pipelined ripple-carry adder/subtractor
//
// Purpose : N-bit a+b+cin or a-b, one W=N/STAGES-bit chunk rippled per stage,
//           valid/ready on both sides with per-stage backpressure.
// Ports   : clk, rst (async, active high)
//           in_valid/in_ready, a[N-1:0], b[N-1:0], cin, sub   (operand beat)
//           out_valid/out_ready, sum[N-1:0], cout             (result beat)
//           ovf (only when PIPELINED_RC_ADDER_OVF_EN is defined): signed overflow
module pipelined_rc_adder
    import adder_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef PIPELINED_RC_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int W = chunk_w(N, STAGES);

    if (!cfg_ok(N, STAGES)) begin : g_cfg_check
        $error("pipelined_rc_adder: N must be >= 1 and evenly divided into 1..N stages");
    end

    // Subtraction is a + ~b + 1, so the operand inversion and forced carry
    // happen once at the input and the stages only ever add.
    logic [N-1:0] w_bx;
    logic         w_c0;
    assign w_bx = sub ? ~b : b;
    assign w_c0 = sub | cin;

    stage_ctl_t   r_ctl [STAGES];
    // r_x rotates right by W each stage: the consumed a-chunk falls off the
    // bottom and its sum chunk enters at the top, so after STAGES stages r_x
    // holds the complete sum in natural bit order. r_y shifts b' the same way.
    logic [N-1:0] r_x   [STAGES];
    logic [N-1:0] r_y   [STAGES];

    logic [N-1:0] w_xa  [STAGES];
    logic [N-1:0] w_yb  [STAGES];
    logic [W-1:0] w_s   [STAGES];
    logic [STAGES-1:0] w_ci;
    logic [STAGES-1:0] w_co;
    logic [STAGES-1:0] w_cm;
    logic [STAGES-1:0] w_srcv;
    logic [STAGES-1:0] w_load;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_xa[k]   = a;
            assign w_yb[k]   = w_bx;
            assign w_ci[k]   = w_c0;
            assign w_srcv[k] = in_valid;
        end else begin : g_body
            assign w_xa[k]   = r_x[k-1];
            assign w_yb[k]   = r_y[k-1];
            assign w_ci[k]   = r_ctl[k-1].carry;
            assign w_srcv[k] = r_ctl[k-1].valid;
        end

        rc_chunk #(.W(W)) u_chunk (
            .a     (w_xa[k][W-1:0]),
            .b     (w_yb[k][W-1:0]),
            .cin   (w_ci[k]),
            .sum   (w_s[k]),
            .cout  (w_co[k]),
            .c_msb (w_cm[k])
        );
    end

    // A stage may load if it or any later stage is empty, or the consumer is
    // taking the output: that is exactly "empty or next stage loads" unrolled.
    // Depends only on valid bits and out_ready, never on in_valid.
    always_comb begin
        logic w_full;
        w_load = '0;
        w_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_full    = w_full & r_ctl[k].valid;
            w_load[k] = out_ready | ~w_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k] <= '0;
                r_x[k]   <= '0;
                r_y[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_ctl[k].valid <= w_srcv[k];
                    if (w_srcv[k]) begin
                        r_ctl[k].carry <= w_co[k];
                        r_x[k]         <= N'({w_s[k], w_xa[k]} >> W);
                        r_y[k]         <= w_yb[k] >> W;
                    end
                end
            end
        end
    end

`ifdef PIPELINED_RC_ADDER_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_load[STAGES-1] && w_srcv[STAGES-1]) begin
            r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
        end
    end
    assign ovf = r_ovf;
`endif

    // The last stage's b' remainder is always empty and only the top chunk's
    // MSB carry feeds overflow; fold the leftovers into one sink.
    logic w_unused_tail;
    assign w_unused_tail = ^{r_y[STAGES-1], w_cm};

    assign in_ready  = w_load[0];
    assign out_valid = r_ctl[STAGES-1].valid;
    assign sum       = r_x[STAGES-1];
    assign cout      = r_ctl[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// tb/tb_pipelined_rc_adder.sv - self-checking bench for pipelined_rc_adder
module tb_pipelined_rc_adder;

    localparam int N      = 32;
    localparam int STAGES = 4;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_ready = 1'b1;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic [N-1:0] sum;
`ifdef PIPELINED_RC_ADDER_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    pipelined_rc_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_RC_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [N-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_err    = 0;
    int           n_in     = 0;
    int           n_out    = 0;
    logic         prev_stall = 1'b0;
    logic [N-1:0] held_sum   = '0;
    logic         held_cout  = 1'b0;

    // Reference: plain N+1-bit arithmetic and unsigned/signed comparisons.
    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                   input logic ci, input logic s);
        exp_t       e;
        logic [N:0] t;
        if (s) begin
            e.s = x - y;
            e.c = (x >= y);
            e.o = (x[N-1] != y[N-1]) && (e.s[N-1] != x[N-1]);
        end else begin
            t   = {1'b0, x} + {1'b0, y} + (N+1)'(ci);
            e.s = t[N-1:0];
            e.c = t[N];
            e.o = (x[N-1] == y[N-1]) && (e.s[N-1] != x[N-1]);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: score at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", 64'(sum), 64'(held_sum));
            chk("hold_cout", 64'(cout), 64'(held_cout));
        end
        prev_stall = out_valid && !out_ready;
        held_sum   = sum;
        held_cout  = cout;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_beat_queue_len", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("cout", 64'(cout), 64'(e.c));
`ifdef PIPELINED_RC_ADDER_OVF_EN
                chk("ovf", 64'(ovf), 64'(e.o));
`endif
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           lat, base, b_out, stalls, idx, cyc, stale;
        logic [N-1:0] ta [5];
        logic [N-1:0] tbv[5];
        ta  = '{32'd5, 32'd7, 32'd9, 32'd3, 32'd100};
        tbv = '{32'd7, 32'd5, 32'd3, 32'd9, 32'd1};

        // Asynchronous reset, observed before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic add: latency and single-cycle result.
        a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("basic_sum", 64'(sum), 64'h0001_0000);
        tick();
        chk("valid_one_cycle", 64'(out_valid), 64'd0);

        // Carry ripples through every chunk.
        a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; cin = 1'b0;
        drain();

        // Subtract under backpressure: fill, then pass-through on a full pipe.
        out_ready = 1'b0; sub = 1'b1; base = n_in;
        for (int i = 0; i < 6; i++) begin
            idx = n_in - base;
            a = ta[idx]; b = tbv[idx]; in_valid = 1'b1;
            tick();
        end
        chk("fill_accepted", 64'(n_in - base), 64'd4);
        chk("in_ready_full", 64'(in_ready), 64'd0);
        chk("out_valid_full", 64'(out_valid), 64'd1);
        chk("first_sub_sum", 64'(sum), 64'hFFFF_FFFE);
        chk("first_sub_cout", 64'(cout), 64'd0);
        a = ta[4]; b = tbv[4]; out_ready = 1'b1;
        #1;
        chk("in_ready_full_passthru", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; sub = 1'b0;
        drain();

        // Random stream against the reference model.
        base = n_in; cyc = 0;
        while ((n_in - base) < 1000 && cyc < 20000) begin
            a = $urandom; b = $urandom;
            if ($urandom_range(7) == 0) a = '1;
            if ($urandom_range(7) == 0) b = ($urandom_range(1) == 0) ? '0 : '1;
            cin       = 1'($urandom_range(1));
            sub       = 1'($urandom_range(1));
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            tick();
            cyc++;
        end
        chk("random_beats_accepted", 64'(n_in - base), 64'd1000);
        in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Sustained one beat per cycle.
        b_out = n_out; stalls = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            if (!in_ready) stalls++;
            tick();
        end
        chk("sustained_stalls", 64'(stalls), 64'd0);
        chk("sustained_outputs", 64'(n_out - b_out), 64'd46);
        in_valid = 1'b0;
        drain();

        // Reset between edges with beats in flight.
        out_ready = 1'b0; sub = 1'b0; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom | 32'h1; b = $urandom; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1; cin = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) stale++;
            tick();
        end
        chk("no_stale_beat", 64'(stale), 64'd0);

        // Pipeline still works after reset.
        a = 32'h1234_5678; b = 32'h8765_4321; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; sub = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
